wb_dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache. It is the responder end of the MEM/WB data-cache interface: it accepts `rd_req`/`wr_req`/`addr`/`wr_data`, returns `rd_data` and a `miss` stall flag. On a miss it exchanges whole lines with main memory over a line-wide req/ack port. Pipeline stalls (bubbles) while `miss`=1 and holds its request stable.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_stats.sv | 27 ++
 rtl/wb_dcache.sv | 169 ++++++++++++++++
 tb/tb_wb_dcache.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the wb_dcache data cache.
package dcache_pkg;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_SET_ADDR_LEN  = 2;
  localparam int DEF_TAG_ADDR_LEN  = 12;

  localparam int WORD_BITS = 32;
  localparam int WORD_LSB  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SWAP_OUT,
    SWAP_IN,
    SWAP_IN_OK
  } state_e;

  function automatic int line_bits(input int line_addr_len);
    return WORD_BITS << line_addr_len;
  endfunction

  function automatic int set_lsb(input int line_addr_len);
    return WORD_LSB + line_addr_len;
  endfunction

  function automatic int tag_lsb(input int line_addr_len, input int set_addr_len);
    return WORD_LSB + line_addr_len + set_addr_len;
  endfunction

endpackage

// File: rtl/dcache_stats.sv
// Saturating access/miss counters for wb_dcache; cleared by synchronous reset.
module dcache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        access_i,
  input  logic        miss_i,
  output logic [31:0] access_cnt_o,
  output logic [31:0] miss_cnt_o
);

  logic [31:0] access_q;
  logic [31:0] miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      access_q <= '0;
      miss_q   <= '0;
    end else begin
      if (access_i && access_q != '1) access_q <= access_q + 32'd1;
      if (miss_i && miss_q != '1)     miss_q   <= miss_q + 32'd1;
    end
  end

  assign access_cnt_o = access_q;
  assign miss_cnt_o   = miss_q;

endmodule

// File: rtl/wb_dcache.sv
// Direct-mapped write-back, write-allocate data cache with a line-wide memory port.
// Defining DCACHE_STATS_EN adds saturating access_cnt / miss_cnt outputs.
module wb_dcache
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
  parameter int TAG_ADDR_LEN  = DEF_TAG_ADDR_LEN
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [31:0]                           addr,
  input  logic                                  rd_req,
  input  logic                                  wr_req,
  input  logic [31:0]                           wr_data,
  output logic [31:0]                           rd_data,
  output logic                                  miss,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]  mem_addr,
  output logic [line_bits(LINE_ADDR_LEN)-1:0]   mem_wdata,
  input  logic [line_bits(LINE_ADDR_LEN)-1:0]   mem_rdata,
  input  logic                                  mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                           access_cnt,
  output logic [31:0]                           miss_cnt
`endif
);

  localparam int LINE_WORDS = 2 ** LINE_ADDR_LEN;
  localparam int SETS       = 2 ** SET_ADDR_LEN;
  localparam int LINE_W     = line_bits(LINE_ADDR_LEN);
  localparam int SET_LSB    = set_lsb(LINE_ADDR_LEN);
  localparam int TAG_LSB    = tag_lsb(LINE_ADDR_LEN, SET_ADDR_LEN);

  logic [LINE_ADDR_LEN-1:0] off;
  logic [SET_ADDR_LEN-1:0]  set;
  logic [TAG_ADDR_LEN-1:0]  tag;
  logic                     unused_addr_bits;

  assign off = addr[WORD_LSB +: LINE_ADDR_LEN];
  assign set = addr[SET_LSB +: SET_ADDR_LEN];
  assign tag = addr[TAG_LSB +: TAG_ADDR_LEN];
  assign unused_addr_bits = ^{addr[1:0], addr >> (TAG_LSB + TAG_ADDR_LEN)};

  logic [31:0]             data_q [SETS][LINE_WORDS];
  logic [TAG_ADDR_LEN-1:0] tag_q  [SETS];
  logic [SETS-1:0]         valid_q;
  logic [SETS-1:0]         dirty_q;

  state_e                  state_q;
  logic [TAG_ADDR_LEN-1:0] line_tag_q;
  logic [SET_ADDR_LEN-1:0] line_set_q;
  logic [LINE_W-1:0]       fill_q;
  logic [31:0]             rd_data_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr_q;
  logic [LINE_W-1:0]       mem_wdata_q;

  logic              req;
  logic              hit;
  logic              hit_done;
  logic              word_we;
  logic [LINE_W-1:0] victim_line;

  assign req      = rd_req | wr_req;
  assign hit      = valid_q[set] && (tag_q[set] == tag);
  assign hit_done = req && hit && (state_q == IDLE);
  assign miss     = req && !((state_q == IDLE) && hit);
  assign word_we  = hit_done && wr_req;

  // NOTE: assign a default before the loop so no bit of victim_line is left to infer a latch.
  always_comb begin
    victim_line = '0;
    for (int w = 0; w < LINE_WORDS; w++) victim_line[w*32 +: 32] = data_q[set][w];
  end

  // NOTE: the data and tag arrays carry no reset; valid_q alone decides whether an entry is usable.
  always_ff @(posedge clk) begin
    if (!rst && state_q == SWAP_IN_OK) begin
      tag_q[line_set_q] <= line_tag_q;
      for (int w = 0; w < LINE_WORDS; w++) data_q[line_set_q][w] <= fill_q[w*32 +: 32];
    end else if (!rst && word_we) begin
      data_q[set][off] <= wr_data;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_done) begin
            if (wr_req) dirty_q[set] <= 1'b1;
            else        rd_data_q    <= data_q[set][off];
          end else if (req) begin
            line_tag_q <= tag;
            line_set_q <= set;
            mem_req_q  <= 1'b1;
            if (valid_q[set] && dirty_q[set]) begin
              state_q     <= SWAP_OUT;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[set], set};
              mem_wdata_q <= victim_line;
            end else begin
              state_q    <= SWAP_IN;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, set};
            end
          end
        end
        SWAP_OUT: begin
          if (mem_ack) begin
            state_q    <= SWAP_IN;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {line_tag_q, line_set_q};
          end
        end
        SWAP_IN: begin
          if (mem_ack) begin
            state_q   <= SWAP_IN_OK;
            fill_q    <= mem_rdata;
            mem_req_q <= 1'b0;
          end
        end
        SWAP_IN_OK: begin
          valid_q[line_set_q] <= 1'b1;
          dirty_q[line_set_q] <= 1'b0;
          state_q             <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic miss_start;
  assign miss_start = req && !hit && (state_q == IDLE);

  dcache_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .access_i     (hit_done),
    .miss_i       (miss_start),
    .access_cnt_o (access_cnt),
    .miss_cnt_o   (miss_cnt)
  );
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_wb_dcache.sv
// Directed self-checking bench for wb_dcache: cold fill, write hit, dirty and clean
// conflict misses, simultaneous rd/wr, and reset abandoning an in-flight refill.
module tb_wb_dcache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic         rd_req;
  logic         wr_req;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  logic         miss;
  logic         mem_req;
  logic         mem_we;
  logic [13:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  access_cnt;
  logic [31:0]  miss_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  wb_dcache dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .access_cnt(access_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + w;
    return l;
  endfunction

  // Memory side: wait (bounded) for mem_req, capture the request, ack after lat cycles.
  task automatic serve(input int lat, input logic [255:0] line,
                       output logic we, output logic [13:0] a, output logic [255:0] wd);
    int t = 0;
    while (!mem_req && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("mem_req_raised", mem_req, 1'b1);
    we = mem_we;
    a  = mem_addr;
    wd = mem_wdata;
    n_txn++;
    repeat (lat - 1) @(posedge clk);
    #1;
    mem_rdata = line;
    mem_ack   = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  // Wait (bounded) for the retried access to hit, let it complete, then drop the request.
  task automatic finish_access(input string tag);
    int t = 0;
    while (miss && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, miss, 1'b0);
    @(posedge clk); #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [255:0] line_a, line_a_wb, line_c, junk;
    logic         we;
    logic [13:0]  a;
    logic [255:0] wd;

    line_a          = make_line(32'h1000_0000);
    line_a[31:0]    = 32'hDEAD_BEEF;
    line_a_wb       = line_a;
    line_a_wb[63:32] = 32'h1234_5678;
    line_c          = make_line(32'hC0C0_0000);
    junk            = make_line(32'h5555_0000);

    rst = 1'b1; addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_data = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 14'h0);
    check("rst_mem_wdata", mem_wdata, 256'h0);
    check("rst_miss_idle", miss, 1'b0);

    // 1: cold read of 0x40 -> single fetch of line {tag 0, set 2}
    addr = 32'h0000_0040; rd_req = 1'b1;
    #1 check("t1_miss", miss, 1'b1);
    serve(5, line_a, we, a, wd);
    check("t1_we", we, 1'b0);
    check("t1_addr", a, 14'h002);
    begin
      int t = 0;
      while (miss && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
    end
    check("t1_miss_fall", miss, 1'b0);
    check("t1_rd_latency", rd_data, 32'h0);
    @(posedge clk); #1;
    rd_req = 1'b0;
    check("t1_rd_data", rd_data, 32'hDEAD_BEEF);
    check("t1_txns", n_txn, 1);

    // 2: write hit to 0x44, then read it back
    addr = 32'h0000_0044; wr_req = 1'b1; wr_data = 32'h1234_5678;
    #1 check("t2_wr_miss", miss, 1'b0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    check("t2_wr_rd_hold", rd_data, 32'hDEAD_BEEF);
    check("t2_wr_no_req", mem_req, 1'b0);
    rd_req = 1'b1;
    #1 check("t2_rd_miss", miss, 1'b0);
    @(posedge clk); #1;
    rd_req = 1'b0;
    check("t2_rd_data", rd_data, 32'h1234_5678);
    check("t2_no_req", mem_req, 1'b0);

    // 3: dirty conflict at 0xC0 (set 2, tag 1) -> write-back then fetch
    addr = 32'h0000_00C0; rd_req = 1'b1;
    #1 check("t3_miss", miss, 1'b1);
    serve(3, line_a_wb, we, a, wd);
    check("t3_wb_we", we, 1'b1);
    check("t3_wb_addr", a, 14'h002);
    check("t3_wb_data", wd, line_a_wb);
    serve(2, line_c, we, a, wd);
    check("t3_fetch_we", we, 1'b0);
    check("t3_fetch_addr", a, 14'h006);
    finish_access("t3_miss_fall");
    check("t3_rd_data", rd_data, 32'hC0C0_0000);
    check("t3_txns", n_txn, 3);

    // 4: clean conflict back to 0x40 -> fetch only
    addr = 32'h0000_0040; rd_req = 1'b1;
    #1 check("t4_miss", miss, 1'b1);
    serve(1, line_a_wb, we, a, wd);
    check("t4_fetch_we", we, 1'b0);
    check("t4_fetch_addr", a, 14'h002);
    finish_access("t4_miss_fall");
    check("t4_rd_data", rd_data, 32'hDEAD_BEEF);
    check("t4_txns", n_txn, 4);
    check("t4_no_req", mem_req, 1'b0);
`ifdef DCACHE_STATS_EN
    check("stats_access", access_cnt, 32'd5);
    check("stats_miss", miss_cnt, 32'd3);
`endif

    // rd_req and wr_req together behave as a write
    addr = 32'h0000_0040; rd_req = 1'b1; wr_req = 1'b1; wr_data = 32'hA5A5_A5A5;
    #1 check("rw_miss", miss, 1'b0);
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    check("rw_rd_hold", rd_data, 32'hDEAD_BEEF);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    check("rw_readback", rd_data, 32'hA5A5_A5A5);

    // 5: reset during SWAP_IN, stray ack afterwards is ignored
    addr = 32'h0000_0060; rd_req = 1'b1;
    @(posedge clk); #1;
    check("t5_req_up", mem_req, 1'b1);
    check("t5_fetch_addr", mem_addr, 14'h003);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rd_req = 1'b0;
    #1;
    check("t5_rst_req", mem_req, 1'b0);
    check("t5_rst_we", mem_we, 1'b0);
    check("t5_rst_addr", mem_addr, 14'h0);
    check("t5_rst_rd", rd_data, 32'h0);
    check("t5_rst_miss", miss, 1'b0);
`ifdef DCACHE_STATS_EN
    check("t5_stats_access", access_cnt, 32'd0);
    check("t5_stats_miss", miss_cnt, 32'd0);
`endif
    mem_rdata = junk; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("t5_stray_req", mem_req, 1'b0);
    @(posedge clk); #1;
    check("t5_stray_req2", mem_req, 1'b0);
    addr = 32'h0000_0040; rd_req = 1'b1;
    #1 check("t5_remiss", miss, 1'b1);
    serve(2, line_a_wb, we, a, wd);
    check("t5_refetch_we", we, 1'b0);
    check("t5_refetch_addr", a, 14'h002);
    finish_access("t5_miss_fall");
    check("t5_rd_data", rd_data, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
